// File: rtl/regfile_sb.sv
// Dual-write, dual-read register file with a per-register busy scoreboard for RAW hazard detection.
// Reads and busy lookups are combinational; writes and busy updates take effect at the clock edge.
module regfile_sb #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic [DW-1:0] rd_data_a,
  output logic [DW-1:0] rd_data_b,
  output logic          rd_busy_a,
  output logic          rd_busy_b,
  input  logic          we0,
  input  logic [AW-1:0] wa0,
  input  logic [DW-1:0] wd0,
  input  logic          we1,
  input  logic [AW-1:0] wa1,
  input  logic [DW-1:0] wd1,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_addr,
  input  logic          flush,
  output logic [AW:0]   busy_cnt
);

  localparam int NREG = 1 << AW;
  localparam bit ZR   = (ZERO_REG != 0);
  localparam bit BP   = (BYPASS != 0);

  logic [DW-1:0]   mem_q [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [NREG-1:0] wr_clr, iss_set;
  logic            wr0, wr1, iss;

  // Qualified strobes: register 0 is never written or tracked, and nothing
  // is forwarded or committed while reset is held.
  assign wr0 = rst && we0 && !(ZR && (wa0 == '0));
  assign wr1 = rst && we1 && !(ZR && (wa1 == '0));
  assign iss = rst && iss_valid && !(ZR && (iss_addr == '0));

  assign wr_clr  = (wr0 ? (NREG'(1) << wa0) : '0) | (wr1 ? (NREG'(1) << wa1) : '0);
  assign iss_set = iss ? (NREG'(1) << iss_addr) : '0;

  // Issue is OR-ed in after the writeback clear so the newest producer wins.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      busy_d = (busy_q & ~wr_clr) | iss_set;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      if (wr0) mem_q[wa0] <= wd0;
      if (wr1) mem_q[wa1] <= wd1;
      busy_q <= busy_d;
    end
  end

  logic [AW-1:0] rd_addr [2];
  logic [DW-1:0] rd_data [2];
  logic          rd_busy [2];

  assign rd_addr[0] = rd_addr_a;
  assign rd_addr[1] = rd_addr_b;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = mem_q[rd_addr[p]];
      rd_busy[p] = busy_q[rd_addr[p]];
      if (BP) begin
        if (wr0 && (wa0 == rd_addr[p])) begin
          rd_data[p] = wd0;
          rd_busy[p] = 1'b0;
        end
        if (wr1 && (wa1 == rd_addr[p])) begin
          rd_data[p] = wd1;
          rd_busy[p] = 1'b0;
        end
      end
      if (ZR && (rd_addr[p] == '0)) begin
        rd_data[p] = '0;
        rd_busy[p] = 1'b0;
      end
    end
  end

  assign rd_data_a = rd_data[0];
  assign rd_data_b = rd_data[1];
  assign rd_busy_a = rd_busy[0];
  assign rd_busy_b = rd_busy[1];

  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < NREG; i++) begin
      busy_cnt = busy_cnt + (AW+1)'(busy_q[i]);
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios plus a randomized scoreboard phase,
// with a BYPASS=0 instance sharing the same stimulus.
module tb_regfile_sb;

  logic        clk, rst;
  logic [4:0]  rd_addr_a, rd_addr_b, wa0, wa1, iss_addr;
  logic        we0, we1, iss_valid, flush;
  logic [31:0] wd0, wd1;
  logic [31:0] rd_data_a, rd_data_b, nb_rd_data_a, nb_rd_data_b;
  logic        rd_busy_a, rd_busy_b, nb_rd_busy_a, nb_rd_busy_b;
  logic [5:0]  busy_cnt, nb_busy_cnt;

  int checks = 0;
  int passed = 0;

  typedef struct packed {
    logic [31:0] da;
    logic [31:0] db;
    logic [31:0] nda;
    logic        ba;
    logic        bb;
    logic [5:0]  cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_m [32];
  logic [31:0] busy_m;

  regfile_sb #(.DW(32), .AW(5), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .rd_busy_a(rd_busy_a), .rd_busy_b(rd_busy_b),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .flush(flush), .busy_cnt(busy_cnt)
  );

  regfile_sb #(.DW(32), .AW(5), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(nb_rd_data_a), .rd_data_b(nb_rd_data_b),
    .rd_busy_a(nb_rd_busy_a), .rd_busy_b(nb_rd_busy_b),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .flush(flush), .busy_cnt(nb_busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 0; wa0 = 0; wd0 = 0;
    we1 = 0; wa1 = 0; wd1 = 0;
    iss_valid = 0; iss_addr = 0; flush = 0;
  endtask

  task automatic test_reset();
    idle();
    rd_addr_a = 5; rd_addr_b = 5;
    rst = 1;
    #1 rst = 0;
    we0 = 1; wa0 = 5; wd0 = 32'hDEAD_BEEF;
    iss_valid = 1; iss_addr = 5;
    #2;
    checks++; if (rd_data_a !== 32'h0) $display("FAIL reset_rd_data_a: got %h want 0", rd_data_a); else passed++;
    checks++; if (rd_busy_a !== 1'b0) $display("FAIL reset_rd_busy_a: got %b want 0", rd_busy_a); else passed++;
    checks++; if (busy_cnt !== 6'd0) $display("FAIL reset_busy_cnt: got %0d want 0", busy_cnt); else passed++;
    @(posedge clk);
    #1;
    checks++; if (rd_data_b !== 32'h0) $display("FAIL reset_after_edge_rd_data_b: got %h want 0", rd_data_b); else passed++;
    idle();
    #3 rst = 1;
  endtask

  task automatic test_write_read();
    step();
    we0 = 1; wa0 = 5; wd0 = 32'h1234_5678; rd_addr_a = 3;
    step();
    idle(); rd_addr_a = 5;
    #1;
    checks++; if (rd_data_a !== 32'h1234_5678) $display("FAIL write_read: got %h want 12345678", rd_data_a); else passed++;
    checks++; if (nb_rd_data_a !== 32'h1234_5678) $display("FAIL write_read_nb: got %h want 12345678", nb_rd_data_a); else passed++;
  endtask

  task automatic test_zero_reg();
    step();
    we0 = 1; wa0 = 0; wd0 = 32'hFFFF_FFFF; rd_addr_a = 0;
    #1;
    checks++; if (rd_data_a !== 32'h0) $display("FAIL zero_bypass: got %h want 0", rd_data_a); else passed++;
    step();
    idle(); iss_valid = 1; iss_addr = 0;
    #1;
    checks++; if (rd_data_a !== 32'h0) $display("FAIL zero_read: got %h want 0", rd_data_a); else passed++;
    step();
    idle();
    #1;
    checks++; if (rd_busy_a !== 1'b0) $display("FAIL zero_busy: got %b want 0", rd_busy_a); else passed++;
    checks++; if (busy_cnt !== 6'd0) $display("FAIL zero_busy_cnt: got %0d want 0", busy_cnt); else passed++;
  endtask

  task automatic test_dual_write();
    step();
    we0 = 1; wa0 = 7; wd0 = 32'h1111_1111;
    step();
    idle();
    we0 = 1; wa0 = 7; wd0 = 32'hAAAA_0000;
    we1 = 1; wa1 = 7; wd1 = 32'h0000_BBBB;
    rd_addr_a = 7;
    #1;
    checks++; if (rd_data_a !== 32'h0000_BBBB) $display("FAIL dual_bypass: got %h want 0000bbbb", rd_data_a); else passed++;
    checks++; if (nb_rd_data_a !== 32'h1111_1111) $display("FAIL dual_nobypass: got %h want 11111111", nb_rd_data_a); else passed++;
    step();
    idle();
    we0 = 1; wa0 = 8; wd0 = 32'h0808_0808; rd_addr_b = 8;
    #1;
    checks++; if (rd_data_a !== 32'h0000_BBBB) $display("FAIL dual_commit: got %h want 0000bbbb", rd_data_a); else passed++;
    checks++; if (nb_rd_data_a !== 32'h0000_BBBB) $display("FAIL dual_commit_nb: got %h want 0000bbbb", nb_rd_data_a); else passed++;
    checks++; if (rd_data_b !== 32'h0808_0808) $display("FAIL port0_bypass: got %h want 08080808", rd_data_b); else passed++;
    checks++; if (nb_rd_data_b !== 32'h0) $display("FAIL port0_nobypass: got %h want 0", nb_rd_data_b); else passed++;
    step();
    idle();
  endtask

  task automatic test_issue_wb();
    iss_valid = 1; iss_addr = 3; rd_addr_a = 3;
    #1;
    checks++; if (rd_busy_a !== 1'b0) $display("FAIL issue_same_cycle: got %b want 0", rd_busy_a); else passed++;
    step();
    idle();
    #1;
    checks++; if (rd_busy_a !== 1'b1) $display("FAIL issue_busy: got %b want 1", rd_busy_a); else passed++;
    checks++; if (busy_cnt !== 6'd1) $display("FAIL issue_cnt: got %0d want 1", busy_cnt); else passed++;
    step();
    we0 = 1; wa0 = 3; wd0 = 32'h55;
    #1;
    checks++; if (rd_busy_a !== 1'b0) $display("FAIL wb_busy_fwd: got %b want 0", rd_busy_a); else passed++;
    checks++; if (rd_data_a !== 32'h55) $display("FAIL wb_data_fwd: got %h want 55", rd_data_a); else passed++;
    checks++; if (nb_rd_busy_a !== 1'b1) $display("FAIL wb_busy_nb: got %b want 1", nb_rd_busy_a); else passed++;
    checks++; if (busy_cnt !== 6'd1) $display("FAIL wb_cnt_same: got %0d want 1", busy_cnt); else passed++;
    step();
    idle();
    #1;
    checks++; if (busy_cnt !== 6'd0) $display("FAIL wb_cnt_next: got %0d want 0", busy_cnt); else passed++;
    checks++; if (nb_rd_busy_a !== 1'b0) $display("FAIL wb_busy_next_nb: got %b want 0", nb_rd_busy_a); else passed++;
  endtask

  task automatic test_issue_wb_same();
    step();
    iss_valid = 1; iss_addr = 4;
    we1 = 1; wa1 = 4; wd1 = 32'hCAFE_F00D;
    step();
    idle(); rd_addr_a = 4;
    #1;
    checks++; if (nb_rd_busy_a !== 1'b1) $display("FAIL iss_wb_busy: got %b want 1", nb_rd_busy_a); else passed++;
    checks++; if (rd_data_a !== 32'hCAFE_F00D) $display("FAIL iss_wb_data: got %h want cafef00d", rd_data_a); else passed++;
    checks++; if (busy_cnt !== 6'd1) $display("FAIL iss_wb_cnt: got %0d want 1", busy_cnt); else passed++;
    step();
    we0 = 1; wa0 = 4; wd0 = 32'hCAFE_F00D;
    step();
    idle();
  endtask

  task automatic test_flush();
    iss_valid = 1; iss_addr = 1;
    step();
    iss_addr = 2;
    step();
    iss_addr = 9;
    step();
    idle();
    #1;
    checks++; if (busy_cnt !== 6'd3) $display("FAIL flush_pre_cnt: got %0d want 3", busy_cnt); else passed++;
    step();
    flush = 1; iss_valid = 1; iss_addr = 10;
    we0 = 1; wa0 = 2; wd0 = 32'h22;
    step();
    idle(); rd_addr_a = 10; rd_addr_b = 1;
    #1;
    checks++; if (busy_cnt !== 6'd0) $display("FAIL flush_cnt: got %0d want 0", busy_cnt); else passed++;
    checks++; if (nb_rd_busy_a !== 1'b0) $display("FAIL flush_busy_r10: got %b want 0", nb_rd_busy_a); else passed++;
    checks++; if (nb_rd_busy_b !== 1'b0) $display("FAIL flush_busy_r1: got %b want 0", nb_rd_busy_b); else passed++;
  endtask

  task automatic test_async_reset();
    step();
    iss_valid = 1; iss_addr = 11;
    we1 = 1; wa1 = 12; wd1 = 32'h77;
    step();
    idle(); rd_addr_a = 12; rd_addr_b = 5;
    #1;
    checks++; if (busy_cnt !== 6'd1) $display("FAIL pre_rst_cnt: got %0d want 1", busy_cnt); else passed++;
    checks++; if (rd_data_a !== 32'h77) $display("FAIL pre_rst_data: got %h want 77", rd_data_a); else passed++;
    #1 rst = 0;
    #1;
    checks++; if (rd_data_a !== 32'h0) $display("FAIL async_rst_r12: got %h want 0", rd_data_a); else passed++;
    checks++; if (rd_data_b !== 32'h0) $display("FAIL async_rst_r5: got %h want 0", rd_data_b); else passed++;
    checks++; if (busy_cnt !== 6'd0) $display("FAIL async_rst_cnt: got %0d want 0", busy_cnt); else passed++;
    #3 rst = 1;
  endtask

  task automatic test_random();
    exp_t e, got;
    int   n;
    for (int i = 0; i < 32; i++) mem_m[i] = 32'h0;
    busy_m = 32'h0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      step();
      we0 = 1'($urandom_range(0, 1)); wa0 = 5'($urandom_range(0, 7)); wd0 = $urandom;
      we1 = 1'($urandom_range(0, 1)); wa1 = 5'($urandom_range(0, 7)); wd1 = $urandom;
      iss_valid = 1'($urandom_range(0, 1)); iss_addr = 5'($urandom_range(0, 7));
      flush = ($urandom_range(0, 15) == 0);
      rd_addr_a = 5'($urandom_range(0, 7)); rd_addr_b = 5'($urandom_range(0, 7));
      e.da = mem_m[rd_addr_a]; e.ba = busy_m[rd_addr_a];
      if (we0 && wa0 == rd_addr_a) begin e.da = wd0; e.ba = 0; end
      if (we1 && wa1 == rd_addr_a) begin e.da = wd1; e.ba = 0; end
      if (rd_addr_a == 0) begin e.da = 0; e.ba = 0; end
      e.db = mem_m[rd_addr_b]; e.bb = busy_m[rd_addr_b];
      if (we0 && wa0 == rd_addr_b) begin e.db = wd0; e.bb = 0; end
      if (we1 && wa1 == rd_addr_b) begin e.db = wd1; e.bb = 0; end
      if (rd_addr_b == 0) begin e.db = 0; e.bb = 0; end
      e.nda = (rd_addr_a == 0) ? 32'h0 : mem_m[rd_addr_a];
      n = 0;
      for (int r = 0; r < 32; r++) n += int'(busy_m[r]);
      e.cnt = 6'(n);
      exp_q.push_back(e);
      if (we0 && wa0 != 0) mem_m[wa0] = wd0;
      if (we1 && wa1 != 0) mem_m[wa1] = wd1;
      if (flush) busy_m = 32'h0;
      else begin
        if (we0) busy_m[wa0] = 1'b0;
        if (we1) busy_m[wa1] = 1'b0;
        if (iss_valid && iss_addr != 0) busy_m[iss_addr] = 1'b1;
      end
      #1;
      got = exp_q.pop_front();
      checks++; if (rd_data_a !== got.da) $display("FAIL rnd_data_a cyc %0d: got %h want %h", cyc, rd_data_a, got.da); else passed++;
      checks++; if (rd_data_b !== got.db) $display("FAIL rnd_data_b cyc %0d: got %h want %h", cyc, rd_data_b, got.db); else passed++;
      checks++; if (rd_busy_a !== got.ba) $display("FAIL rnd_busy_a cyc %0d: got %b want %b", cyc, rd_busy_a, got.ba); else passed++;
      checks++; if (rd_busy_b !== got.bb) $display("FAIL rnd_busy_b cyc %0d: got %b want %b", cyc, rd_busy_b, got.bb); else passed++;
      checks++; if (busy_cnt !== got.cnt) $display("FAIL rnd_busy_cnt cyc %0d: got %0d want %0d", cyc, busy_cnt, got.cnt); else passed++;
      checks++; if (nb_rd_data_a !== got.nda) $display("FAIL rnd_nb_data_a cyc %0d: got %h want %h", cyc, nb_rd_data_a, got.nda); else passed++;
    end
    step();
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_dual_write();
    test_issue_wb();
    test_issue_wb_same();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
